// File: rtl/rd_pkg.sv
// Shared constants for the register-read stage: control-bundle field
// positions, default bundle width and the hard-wired zero register index.
package rd_pkg;

  localparam int CTRL_W_DEF = 16;
  localparam int ZERO_IDX   = 0;

  // Bit positions inside DecCtrl / EX_Ctrl; RD passes the bundle through untouched.
  localparam int CTRL_ALUFN_LSB   = 0;
  localparam int CTRL_ALUFN_W     = 4;
  localparam int CTRL_ALUSRC1     = 4;
  localparam int CTRL_ALUSRC2     = 5;
  localparam int CTRL_MEMWR       = 6;
  localparam int CTRL_REGWSRC_LSB = 7;
  localparam int CTRL_REGWSRC_W   = 2;
  localparam int CTRL_SHAMT_LSB   = 9;
  localparam int CTRL_SHAMT_W     = 5;

endpackage

// File: rtl/gp_regfile.sv
// General-purpose register file: two combinational read ports with same-cycle
// writeback bypass, one write port, synchronous active-low clear.
module gp_regfile
  import rd_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ZERO_REG   = 1
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [REG_ADDR_W-1:0] i_ra,
  input  logic [REG_ADDR_W-1:0] i_rb,
  input  logic                  i_we,
  input  logic [REG_ADDR_W-1:0] i_wa,
  input  logic [DATA_W-1:0]     i_wd,
  output logic [DATA_W-1:0]     o_rda,
  output logic [DATA_W-1:0]     o_rdb
);

  localparam int DEPTH = 2 ** REG_ADDR_W;
  localparam logic [REG_ADDR_W-1:0] ZERO_A = REG_ADDR_W'(ZERO_IDX);

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic w_wr_ok;
  logic w_zero_a;
  logic w_zero_b;

  assign w_wr_ok  = i_we && !((ZERO_REG != 0) && (i_wa == ZERO_A));
  assign w_zero_a = (ZERO_REG != 0) && (i_ra == ZERO_A);
  assign w_zero_b = (ZERO_REG != 0) && (i_rb == ZERO_A);

  // NOTE: the array is cleared on reset because the architecture promises
  // zeroed registers; this rules out a plain RAM macro for the storage.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_ok) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  assign o_rda = w_zero_a                    ? '0   :
                 (w_wr_ok && i_wa == i_ra)   ? i_wd : r_mem[i_ra];
  assign o_rdb = w_zero_b                    ? '0   :
                 (w_wr_ok && i_wa == i_rb)   ? i_wd : r_mem[i_rb];

endmodule

// File: rtl/rd_stage_pipe.sv
// Register-read stage: operand read with WB bypass, load-use bubble
// insertion, and the RD/EX pipeline register with valid/ready and flush.
module rd_stage_pipe
  import rd_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CTRL_W     = CTRL_W_DEF,
  parameter int ZERO_REG   = 1,
  parameter int CNT_W      = 16
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  IF_Valid,
  output logic                  RD_Ready,
  input  logic [REG_ADDR_W-1:0] DecRs,
  input  logic [REG_ADDR_W-1:0] DecRt,
  input  logic [REG_ADDR_W-1:0] DecRd,
  input  logic                  DecUsesRs,
  input  logic                  DecUsesRt,
  input  logic                  DecRegWr,
  input  logic                  DecMemRd,
  input  logic [DATA_W-1:0]     DecImm,
  input  logic [CTRL_W-1:0]     DecCtrl,
  input  logic [DATA_W-1:0]     PCValP4,
  input  logic [REG_ADDR_W-1:0] WB_Rd,
  input  logic                  WB_RegWr,
  input  logic [DATA_W-1:0]     WB_RegWVal,
  input  logic                  Flush,
  input  logic                  EX_Ready,
  output logic                  EX_Valid,
  output logic [REG_ADDR_W-1:0] EX_Rs,
  output logic [REG_ADDR_W-1:0] EX_Rt,
  output logic [REG_ADDR_W-1:0] EX_Rd,
  output logic [DATA_W-1:0]     EX_RsVal,
  output logic [DATA_W-1:0]     EX_RtVal,
  output logic [DATA_W-1:0]     EX_Imm,
  output logic [DATA_W-1:0]     EX_PCValP4,
  output logic                  EX_RegWr,
  output logic                  EX_MemRd,
  output logic [CTRL_W-1:0]     EX_Ctrl,
  output logic [CNT_W-1:0]      StallCnt
);

  localparam logic [REG_ADDR_W-1:0] ZERO_A = REG_ADDR_W'(ZERO_IDX);

  logic [DATA_W-1:0] w_rs_val;
  logic [DATA_W-1:0] w_rt_val;
  logic              w_ld_dst_live;
  logic              w_hz;

  gp_regfile #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W),
    .ZERO_REG   (ZERO_REG)
  ) u_regfile (
    .Clk   (Clk),
    .Rst   (Rst),
    .i_ra  (DecRs),
    .i_rb  (DecRt),
    .i_we  (WB_RegWr),
    .i_wa  (WB_Rd),
    .i_wd  (WB_RegWVal),
    .o_rda (w_rs_val),
    .o_rdb (w_rt_val)
  );

  // A load into the zero register produces nothing a consumer could wait on.
  assign w_ld_dst_live = (EX_Rd != ZERO_A) || (ZERO_REG == 0);
  assign w_hz = IF_Valid && EX_Valid && EX_MemRd && w_ld_dst_live &&
                ((DecUsesRs && DecRs == EX_Rd) || (DecUsesRt && DecRt == EX_Rd));

  assign RD_Ready = Flush || (EX_Ready && !w_hz);

  // NOTE: state uses non-blocking assignments so every branch sees the
  // pre-edge EX_* values; unassigned fields in a branch simply hold.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      EX_Valid   <= 1'b0;
      EX_Rs      <= '0;
      EX_Rt      <= '0;
      EX_Rd      <= '0;
      EX_RsVal   <= '0;
      EX_RtVal   <= '0;
      EX_Imm     <= '0;
      EX_PCValP4 <= '0;
      EX_RegWr   <= 1'b0;
      EX_MemRd   <= 1'b0;
      EX_Ctrl    <= '0;
      StallCnt   <= '0;
    end else if (!EX_Ready) begin
      // EX is stalled: the whole RD/EX register holds.
    end else if (Flush) begin
      EX_Valid <= 1'b0;
    end else if (w_hz) begin
      EX_Valid <= 1'b0;
      if (StallCnt != '1) StallCnt <= StallCnt + 1'b1;
    end else begin
      EX_Valid   <= IF_Valid;
      EX_Rs      <= DecRs;
      EX_Rt      <= DecRt;
      EX_Rd      <= DecRd;
      EX_RsVal   <= w_rs_val;
      EX_RtVal   <= w_rt_val;
      EX_Imm     <= DecImm;
      EX_PCValP4 <= PCValP4;
      EX_RegWr   <= DecRegWr;
      EX_MemRd   <= DecMemRd;
      EX_Ctrl    <= DecCtrl;
    end
  end

endmodule

// File: tb/tb_rd_stage_pipe.sv
// Self-checking bench for rd_stage_pipe: directed scenarios with literal
// expectations, then randomized traffic compared against a behavioural model.
module tb_rd_stage_pipe;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int CW   = 16;
  localparam int ZR   = 1;
  localparam int CNTW = 4;
  localparam int CNT_MAX = (1 << CNTW) - 1;

  logic          Clk, Rst;
  logic          IF_Valid, RD_Ready;
  logic [AW-1:0] DecRs, DecRt, DecRd;
  logic          DecUsesRs, DecUsesRt, DecRegWr, DecMemRd;
  logic [DW-1:0] DecImm, PCValP4;
  logic [CW-1:0] DecCtrl;
  logic [AW-1:0] WB_Rd;
  logic          WB_RegWr;
  logic [DW-1:0] WB_RegWVal;
  logic          Flush, EX_Ready, EX_Valid;
  logic [AW-1:0] EX_Rs, EX_Rt, EX_Rd;
  logic [DW-1:0] EX_RsVal, EX_RtVal, EX_Imm, EX_PCValP4;
  logic          EX_RegWr, EX_MemRd;
  logic [CW-1:0] EX_Ctrl;
  logic [CNTW-1:0] StallCnt;

  rd_stage_pipe #(
    .DATA_W(DW), .REG_ADDR_W(AW), .CTRL_W(CW), .ZERO_REG(ZR), .CNT_W(CNTW)
  ) dut (
    .Clk(Clk), .Rst(Rst), .IF_Valid(IF_Valid), .RD_Ready(RD_Ready),
    .DecRs(DecRs), .DecRt(DecRt), .DecRd(DecRd),
    .DecUsesRs(DecUsesRs), .DecUsesRt(DecUsesRt),
    .DecRegWr(DecRegWr), .DecMemRd(DecMemRd),
    .DecImm(DecImm), .DecCtrl(DecCtrl), .PCValP4(PCValP4),
    .WB_Rd(WB_Rd), .WB_RegWr(WB_RegWr), .WB_RegWVal(WB_RegWVal),
    .Flush(Flush), .EX_Ready(EX_Ready), .EX_Valid(EX_Valid),
    .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_Rd(EX_Rd),
    .EX_RsVal(EX_RsVal), .EX_RtVal(EX_RtVal), .EX_Imm(EX_Imm),
    .EX_PCValP4(EX_PCValP4), .EX_RegWr(EX_RegWr), .EX_MemRd(EX_MemRd),
    .EX_Ctrl(EX_Ctrl), .StallCnt(StallCnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic          v;
    logic [AW-1:0] rs, rt, rd;
    logic [DW-1:0] rsv, rtv, imm, pc;
    logic          rw, mr;
    logic [CW-1:0] ctrl;
  } ex_t;

  logic [DW-1:0] m_rf [32];
  ex_t           m_ex;
  int            m_cnt;
  bit            model_ok = 0;

  // What an instruction sees when it reads register idx right now.
  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] idx);
    if (idx == 0) return '0;
    if (WB_RegWr && WB_Rd == idx) return WB_RegWVal;
    return m_rf[idx];
  endfunction

  // The instruction in RD needs the value a load currently in EX will produce.
  function automatic bit m_load_use();
    bit needs;
    needs = (DecUsesRs && DecRs == m_ex.rd) || (DecUsesRt && DecRt == m_ex.rd);
    return IF_Valid && m_ex.v && m_ex.mr && (m_ex.rd != 0) && needs;
  endfunction

  always @(posedge Clk) begin
    if (!Rst) begin
      for (int i = 0; i < 32; i++) m_rf[i] <= '0;
      m_ex     <= '0;
      m_cnt    <= 0;
      model_ok <= 1;
    end else begin
      if (EX_Ready) begin
        if (Flush) m_ex.v <= 1'b0;
        else if (m_load_use()) begin
          m_ex.v <= 1'b0;
          m_cnt  <= (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
        end else begin
          m_ex <= '{v: IF_Valid, rs: DecRs, rt: DecRt, rd: DecRd,
                    rsv: m_read(DecRs), rtv: m_read(DecRt), imm: DecImm,
                    pc: PCValP4, rw: DecRegWr, mr: DecMemRd, ctrl: DecCtrl};
        end
      end
      if (WB_RegWr && WB_Rd != 0) m_rf[WB_Rd] <= WB_RegWVal;
    end
  end

  always @(negedge Clk) begin
    if (model_ok) begin
      check("rd_ready", RD_Ready, Flush || (EX_Ready && !m_load_use()));
      check("ex_valid", EX_Valid, m_ex.v);
      check("ex_rs",    EX_Rs,    m_ex.rs);
      check("ex_rt",    EX_Rt,    m_ex.rt);
      check("ex_rd",    EX_Rd,    m_ex.rd);
      check("ex_rsval", EX_RsVal, m_ex.rsv);
      check("ex_rtval", EX_RtVal, m_ex.rtv);
      check("ex_imm",   EX_Imm,   m_ex.imm);
      check("ex_pc",    EX_PCValP4, m_ex.pc);
      check("ex_regwr", EX_RegWr, m_ex.rw);
      check("ex_memrd", EX_MemRd, m_ex.mr);
      check("ex_ctrl",  EX_Ctrl,  m_ex.ctrl);
      check("stallcnt", StallCnt, 64'(m_cnt));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic quiet();
    IF_Valid = 0; DecRs = '0; DecRt = '0; DecRd = '0;
    DecUsesRs = 0; DecUsesRt = 0; DecRegWr = 0; DecMemRd = 0;
    DecImm = '0; DecCtrl = '0; PCValP4 = '0;
    WB_Rd = '0; WB_RegWr = 0; WB_RegWVal = '0;
    Flush = 0; EX_Ready = 1;
  endtask

  task automatic set_instr(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                           input logic [AW-1:0] rd, input logic urs, input logic urt,
                           input logic rw, input logic mr);
    IF_Valid = 1; DecRs = rs; DecRt = rt; DecRd = rd;
    DecUsesRs = urs; DecUsesRt = urt; DecRegWr = rw; DecMemRd = mr;
    DecImm = $urandom; DecCtrl = CW'($urandom); PCValP4 = $urandom;
  endtask

  initial begin
    quiet();
    Rst = 0;
    set_instr(5, 6, 7, 1, 1, 1, 1);
    cyc(); cyc();
    check("rst_ex_valid", EX_Valid, 0);
    check("rst_stallcnt", StallCnt, 0);
    check("rst_ex_rsval", EX_RsVal, 0);
    check("rst_ex_imm",   EX_Imm,   0);
    check("rst_ex_ctrl",  EX_Ctrl,  0);
    check("rst_ex_memrd", EX_MemRd, 0);

    Rst = 1;
    set_instr(5, 0, 1, 1, 0, 0, 0);
    cyc();
    check("r5_after_rst", EX_RsVal, 0);
    check("r5_valid",     EX_Valid, 1);

    // Same-cycle writeback bypass, then the stored value.
    WB_RegWr = 1; WB_Rd = 7; WB_RegWVal = 32'hDEADBEEF;
    set_instr(7, 0, 1, 1, 0, 0, 0);
    cyc();
    check("bypass_val",   EX_RsVal, 32'hDEADBEEF);
    check("bypass_valid", EX_Valid, 1);
    WB_RegWr = 0;
    cyc();
    check("stored_r7", EX_RsVal, 32'hDEADBEEF);

    // Zero register ignores writes.
    WB_RegWr = 1; WB_Rd = 0; WB_RegWVal = 32'h1234;
    set_instr(0, 0, 1, 1, 0, 0, 0);
    cyc();
    check("r0_bypass", EX_RsVal, 0);
    WB_RegWr = 0;
    cyc();
    check("r0_read", EX_RsVal, 0);

    // Load-use: one bubble, then the consumer issues.
    set_instr(0, 0, 3, 0, 0, 1, 1);
    cyc();
    check("load_in_ex", EX_MemRd, 1);
    set_instr(3, 0, 4, 1, 0, 1, 0);
    #1 check("lu_not_ready", RD_Ready, 0);
    cyc();
    check("lu_bubble", EX_Valid, 0);
    check("lu_cnt",    StallCnt, 1);
    #1 check("lu_ready_again", RD_Ready, 1);
    cyc();
    check("lu_issue_valid", EX_Valid, 1);
    check("lu_issue_rs",    EX_Rs, 3);

    // Back-pressure with a pending hazard: hold everything, no count.
    set_instr(0, 0, 9, 0, 0, 1, 1);
    cyc();
    set_instr(0, 9, 10, 0, 1, 1, 0);
    EX_Ready = 0;
    repeat (3) begin
      #1 check("bp_not_ready", RD_Ready, 0);
      cyc();
      check("bp_hold_valid", EX_Valid, 1);
      check("bp_hold_rd",    EX_Rd, 9);
      check("bp_cnt",        StallCnt, 1);
    end

    // Flush beats the hazard and does not count.
    EX_Ready = 1; Flush = 1;
    #1 check("flush_ready", RD_Ready, 1);
    cyc();
    check("flush_valid", EX_Valid, 0);
    check("flush_cnt",   StallCnt, 1);
    Flush = 0;

    // Drive the 4-bit counter well past its ceiling.
    repeat ((1 << CNTW) + 2) begin
      set_instr(0, 0, 2, 0, 0, 1, 1);
      cyc();
      set_instr(2, 0, 5, 1, 0, 1, 0);
      cyc();
    end
    check("sat_cnt", StallCnt, 15);

    // Randomized traffic over a small register window to provoke hazards.
    repeat (3000) begin
      Rst        = ($urandom_range(0, 99) != 0);
      IF_Valid   = $urandom_range(0, 3) != 0;
      DecRs      = AW'($urandom_range(0, 7));
      DecRt      = AW'($urandom_range(0, 7));
      DecRd      = AW'($urandom_range(0, 7));
      DecUsesRs  = $urandom_range(0, 1);
      DecUsesRt  = $urandom_range(0, 1);
      DecRegWr   = $urandom_range(0, 1);
      DecMemRd   = $urandom_range(0, 2) == 0;
      DecImm     = $urandom;
      DecCtrl    = CW'($urandom);
      PCValP4    = $urandom;
      WB_Rd      = AW'($urandom_range(0, 7));
      WB_RegWr   = $urandom_range(0, 1);
      WB_RegWVal = $urandom;
      Flush      = $urandom_range(0, 9) == 0;
      EX_Ready   = $urandom_range(0, 3) != 0;
      cyc();
    end

    @(negedge Clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
